laplace_adder_sequencer: RTL and testbench

Sequencer that computes one 4-neighbour Laplace response, 4*C - N - S - E - W, by time-multiplexing a single external 8-bit adder (exact or approximate ripple-carry) over multiple cycles.
A 16-bit accumulator is built from two 8-bit passes per operation, carrying the adder's carry-out between passes.
It sits between the pixel-window fetch logic and the output pixel writer in the Laplace filter pipeline.
The adder instance stays outside the block, so exact and approximate adders can be swapped without touching this RTL.

---
 rtl/laplace_adder_sequencer_if.sv | 36 +++
 rtl/laplace_adder_sequencer.sv | 111 +++++++++++
 tb/tb_laplace_adder_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/laplace_adder_sequencer_if.sv
// Handshake and adder bus for the Laplace adder sequencer.
// slave is the sequencer's view; master is the surrounding logic
// (window fetch, pixel writer and the external 8-bit adder).
interface laplace_adder_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  pix_c;
    logic [7:0]  pix_n;
    logic [7:0]  pix_s;
    logic [7:0]  pix_e;
    logic [7:0]  pix_w;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_s;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_value;
    logic [7:0]  out_pix;
    logic        busy;

    modport slave (
        input  in_valid, pix_c, pix_n, pix_s, pix_e, pix_w,
        input  add_s, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin,
        output out_valid, out_value, out_pix, busy
    );

    modport master (
        output in_valid, pix_c, pix_n, pix_s, pix_e, pix_w,
        output add_s, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin,
        input  out_valid, out_value, out_pix, busy
    );
endinterface

// File: rtl/laplace_adder_sequencer.sv
// Computes 4*C - N - S - E - W by running a 16-bit accumulator through an
// external 8-bit adder: each neighbour is subtracted as acc + ~{8'h00,X} + 1,
// done as a low-byte pass then a high-byte pass chained through the carry.
module laplace_adder_sequencer #(
    parameter bit SAT_MODE = 1'b1  // 1: min(|acc|,255); 0: clamp to 0..255
) (
    input  logic                        clk,
    input  logic                        rst,
    laplace_adder_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t          state, state_nxt;
    logic [15:0]     acc;
    logic            carry;
    logic [1:0]      op;
    logic [3:0][7:0] opnd;   // N, S, E, W in subtraction order
    logic [7:0]      cur;
    logic [15:0]     mag;
    logic [7:0]      sat;

    assign cur = opnd[op];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus handshake and adder operand drive
    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        bus.out_valid = 1'b0;
        bus.add_a    = 8'h00;
        bus.add_b    = 8'h00;
        bus.add_cin  = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
                if (bus.in_valid) state_nxt = LO;
            end
            LO: begin
                bus.add_a   = acc[7:0];
                bus.add_b   = ~cur;
                bus.add_cin = 1'b1;
                state_nxt   = HI;
            end
            HI: begin
                // high byte of ~{8'h00, X} is always all ones
                bus.add_a   = acc[15:8];
                bus.add_b   = 8'hFF;
                bus.add_cin = carry;
                state_nxt   = (op == 2'd3) ? DONE : LO;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, carry and operand capture; adder results land only at LO/HI edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            carry <= 1'b0;
            op    <= '0;
            opnd  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    opnd <= {bus.pix_w, bus.pix_e, bus.pix_s, bus.pix_n};
                    acc  <= {6'b0, bus.pix_c, 2'b00};
                    op   <= '0;
                end
                LO: begin
                    acc[7:0] <= bus.add_s;
                    carry    <= bus.add_cout;
                end
                HI: begin
                    // high-pass carry-out dropped: arithmetic is mod 2^16
                    acc[15:8] <= bus.add_s;
                    if (op != 2'd3) op <= op + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Output pixel mapping from the signed accumulator
    always_comb begin
        mag = acc[15] ? (~acc + 16'd1) : acc;
        sat = 8'h00;
        if (SAT_MODE) begin
            sat = (mag > 16'd255) ? 8'hFF : mag[7:0];
        end else begin
            if (acc[15])              sat = 8'h00;
            else if (acc > 16'd255)   sat = 8'hFF;
            else                      sat = acc[7:0];
        end
    end

    assign bus.out_value = (state == DONE) ? acc : 16'h0000;
    assign bus.out_pix   = (state == DONE) ? sat : 8'h00;

endmodule

// File: tb/tb_laplace_adder_sequencer.sv
// Bench for laplace_adder_sequencer: one instance per SAT_MODE, both fed the
// same windows, each with an exact 8-bit adder model on its adder bus.
module tb_laplace_adder_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    laplace_adder_sequencer_if bus1 ();
    laplace_adder_sequencer_if bus0 ();

    laplace_adder_sequencer #(.SAT_MODE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    laplace_adder_sequencer #(.SAT_MODE(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    // exact adders
    assign {bus1.add_cout, bus1.add_s} = {1'b0, bus1.add_a} + {1'b0, bus1.add_b} + {8'b0, bus1.add_cin};
    assign {bus0.add_cout, bus0.add_s} = {1'b0, bus0.add_a} + {1'b0, bus0.add_b} + {8'b0, bus0.add_cin};

    typedef struct {
        logic [15:0] v;
        logic [7:0]  p1;
        logic [7:0]  p0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ea [8];
    logic [7:0] eb [8];
    logic       ec [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_pix(input int c, input int n, input int s, input int e, input int w);
        bus1.pix_c = 8'(c); bus1.pix_n = 8'(n); bus1.pix_s = 8'(s); bus1.pix_e = 8'(e); bus1.pix_w = 8'(w);
        bus0.pix_c = 8'(c); bus0.pix_n = 8'(n); bus0.pix_s = 8'(s); bus0.pix_e = 8'(e); bus0.pix_w = 8'(w);
    endtask

    task automatic set_valid(input logic v);
        bus1.in_valid = v; bus0.in_valid = v;
    endtask

    task automatic set_ready(input logic r);
        bus1.out_ready = r; bus0.out_ready = r;
    endtask

    // expected result from the arithmetic formula
    task automatic push_exp(input int c, input int n, input int s, input int e, input int w);
        exp_t x;
        int   v;
        int   m;
        v    = 4 * c - n - s - e - w;
        m    = (v < 0) ? -v : v;
        x.v  = 16'(v);
        x.p1 = (m > 255) ? 8'd255 : 8'(m);
        x.p0 = (v < 0) ? 8'd0 : ((v > 255) ? 8'd255 : 8'(v));
        sb.push_back(x);
    endtask

    // expected per-cycle adder drive for one window
    task automatic build_seq(input int c, input int n, input int s, input int e, input int w);
        logic [15:0] a;
        logic [7:0]  x;
        logic [8:0]  lo;
        int          nb [4];
        nb[0] = n; nb[1] = s; nb[2] = e; nb[3] = w;
        a = {6'b0, 8'(c), 2'b00};
        for (int k = 0; k < 4; k++) begin
            x  = 8'(nb[k]);
            lo = {1'b0, a[7:0]} + {1'b0, ~x} + 9'd1;
            ea[2*k]   = a[7:0];  eb[2*k]   = ~x;    ec[2*k]   = 1'b1;
            ea[2*k+1] = a[15:8]; eb[2*k+1] = 8'hFF; ec[2*k+1] = lo[8];
            a = a - {8'h00, x};
        end
    endtask

    // call at a negedge; returns just after the accepting posedge
    task automatic accept(input int c, input int n, input int s, input int e, input int w);
        int t;
        t = 0;
        while (bus1.in_ready !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (t >= 30) begin
            errors++;
            $display("FAIL accept_timeout observed=in_ready_low required=in_ready_high");
        end
        set_pix(c, n, s, e, w);
        set_valid(1'b1);
        push_exp(c, n, s, e, w);
        @(posedge clk);
        #1;
        set_valid(1'b0);
    endtask

    // edges after accept until out_valid is seen (bounded)
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus1.out_valid === 1'b1) break;
        end
        if (lat >= 20) begin
            errors++;
            $display("FAIL out_valid_timeout observed=low required=high");
        end
    endtask

    task automatic check_out(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s observed=output required=empty_scoreboard", tag);
        end else begin
            x = sb.pop_front();
            chk({tag, "_valid1"}, 32'(bus1.out_valid), 32'd1);
            chk({tag, "_valid0"}, 32'(bus0.out_valid), 32'd1);
            chk({tag, "_value1"}, 32'(bus1.out_value), 32'(x.v));
            chk({tag, "_value0"}, 32'(bus0.out_value), 32'(x.v));
            chk({tag, "_pix1"},   32'(bus1.out_pix),   32'(x.p1));
            chk({tag, "_pix0"},   32'(bus0.out_pix),   32'(x.p0));
        end
    endtask

    // call at a negedge with out_valid high
    task automatic handshake(input string tag);
        set_ready(1'b1);
        @(posedge clk);
        #1;
        set_ready(1'b0);
        @(negedge clk);
        chk({tag, "_hs_valid"}, 32'(bus1.out_valid), 32'd0);
        chk({tag, "_hs_ready"}, 32'(bus1.in_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus1.in_ready),  32'd1);
        chk({tag, "_busy"},      32'(bus1.busy),      32'd0);
        chk({tag, "_out_valid"}, 32'(bus1.out_valid), 32'd0);
        chk({tag, "_out_value"}, 32'(bus1.out_value), 32'd0);
        chk({tag, "_out_pix"},   32'(bus1.out_pix),   32'd0);
        chk({tag, "_add_a"},     32'(bus1.add_a),     32'd0);
        chk({tag, "_add_b"},     32'(bus1.add_b),     32'd0);
        chk({tag, "_add_cin"},   32'(bus1.add_cin),   32'd0);
        chk({tag, "_out_valid0"}, 32'(bus0.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int step;
        int nwin;
        int last;
        int w [3][5];

        rst = 1'b1;
        set_valid(1'b0);
        set_ready(1'b0);
        set_pix(0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // flat window with latency check
        accept(10, 10, 10, 10, 10);
        wait_valid(lat);
        chk("flat_latency", 32'(lat), 32'd8);
        check_out("flat");
        handshake("flat");

        // peak
        accept(255, 0, 0, 0, 0);
        wait_valid(lat);
        check_out("peak");
        handshake("peak");

        // trough
        accept(0, 255, 255, 255, 255);
        wait_valid(lat);
        chk("trough_latency", 32'(lat), 32'd8);
        check_out("trough");
        handshake("trough");

        // back-pressure: outputs held while out_ready low
        accept(50, 10, 20, 30, 40);
        wait_valid(lat);
        check_out("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus1.out_valid), 32'd1);
            chk("hold_value", 32'(bus1.out_value), 32'd100);
            chk("hold_pix1",  32'(bus1.out_pix),   32'd100);
            chk("hold_pix0",  32'(bus0.out_pix),   32'd100);
            chk("hold_in_ready", 32'(bus1.in_ready), 32'd0);
        end
        handshake("hold");

        // reset during HI pass of op 2
        accept(200, 1, 2, 3, 4);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus1.busy), 32'd1);
        chk("abort_hi_b", 32'(bus1.add_b), 32'hFF);
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("abort_no_valid1", 32'(bus1.out_valid), 32'd0);
            chk("abort_no_valid0", 32'(bus0.out_valid), 32'd0);
        end
        accept(3, 1, 1, 1, 1);
        wait_valid(lat);
        chk("after_abort_latency", 32'(lat), 32'd8);
        check_out("after_abort");
        handshake("after_abort");

        // back-to-back with in_valid and out_ready held high
        w[0] = '{7, 1, 2, 3, 4};
        w[1] = '{0, 0, 0, 0, 1};
        w[2] = '{64, 0, 0, 0, 0};
        set_ready(1'b1);
        step = 9;
        nwin = 0;
        last = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (step < 8) begin
                chk("b2b_add_a",   32'(bus1.add_a),   32'(ea[step]));
                chk("b2b_add_b",   32'(bus1.add_b),   32'(eb[step]));
                chk("b2b_add_cin", 32'(bus1.add_cin), 32'(ec[step]));
                step++;
            end else if (step == 8) begin
                check_out("b2b");
                step = 9;
            end else begin
                chk("b2b_in_ready", 32'(bus1.in_ready), 32'd1);
                if (nwin < 3) begin
                    set_pix(w[nwin][0], w[nwin][1], w[nwin][2], w[nwin][3], w[nwin][4]);
                    set_valid(1'b1);
                    push_exp(w[nwin][0], w[nwin][1], w[nwin][2], w[nwin][3], w[nwin][4]);
                    build_seq(w[nwin][0], w[nwin][1], w[nwin][2], w[nwin][3], w[nwin][4]);
                    if (nwin > 0) chk("b2b_spacing", 32'(cyc - last), 32'd10);
                    last = cyc;
                    nwin++;
                    step = 0;
                end else begin
                    set_valid(1'b0);
                    break;
                end
            end
        end
        set_ready(1'b0);
        set_valid(1'b0);
        if (nwin != 3 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete observed=%0d_windows_%0d_pending required=3_windows_0_pending", nwin, sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
